// File: rtl/vc_arb_pkg.sv
// Shared types and sizes for the two-VC weighted round-robin arbiter.
package vc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRV0 = 2'd1,
    SRV1 = 2'd2
  } state_e;

  localparam int BW_DEF = 16;
  localparam int CRW    = 4;
  localparam int CNTW   = 8;

endpackage

// File: rtl/wrr_pick.sv
// Winner selection plus next state/credit for the WRR arbiter.
module wrr_pick
  import vc_arb_pkg::*;
#(
  parameter int W0 = 3,
  parameter int W1 = 1
) (
  input  state_e           state_i,
  input  logic [CRW-1:0]   credit_i,
  input  logic             e0_i,
  input  logic             e1_i,
  input  logic             ok_i,
  output logic             gnt_o,
  output logic             vc_o,
  output state_e           state_o,
  output logic [CRW-1:0]   credit_o
);

  localparam logic [CRW-1:0] W0C = CRW'(W0);
  localparam logic [CRW-1:0] W1C = CRW'(W1);

  logic           same;
  logic [CRW-1:0] wt;

  always_comb begin
    gnt_o    = ok_i && (e0_i || e1_i);
    vc_o     = 1'b0;
    state_o  = state_i;
    credit_o = credit_i;
    unique case (state_i)
      IDLE: vc_o = !e0_i;
      SRV0: vc_o = !(e0_i && ((credit_i < W0C) || !e1_i));
      SRV1: vc_o = e1_i && ((credit_i < W1C) || !e0_i);
      default: vc_o = 1'b0;
    endcase
    same = (state_i == SRV0 && !vc_o) ||
           (state_i == SRV1 && vc_o);
    wt   = vc_o ? W1C : W0C;
    if (gnt_o) begin
      state_o = vc_o ? SRV1 : SRV0;
      // weight already spent: the other VC was idle, start a new run
      if (!same || credit_i >= wt)
        credit_o = CRW'(1);
      else if (credit_i != '1)
        credit_o = credit_i + CRW'(1);
    end
  end

endmodule

// File: rtl/vc_wrr_arbiter.sv
// Drains VC0/VC1 source FIFOs into one downstream FIFO by weight.
module vc_wrr_arbiter
  import vc_arb_pkg::*;
#(
  parameter int BW = BW_DEF,
  parameter int W0 = 3,
  parameter int W1 = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vc0_empty,
  input  logic            vc1_empty,
  input  logic            vc0_almost_empty,
  input  logic            vc1_almost_empty,
  input  logic [BW-1:0]   vc0_data,
  input  logic [BW-1:0]   vc1_data,
  input  logic            out_full,
  input  logic            out_almost_full,
  output logic            vc0_rd,
  output logic            vc1_rd,
  output logic            out_wr,
  output logic [BW-1:0]   out_data,
  output logic            last_vc,
  output logic [CNTW-1:0] cnt0,
  output logic [CNTW-1:0] cnt1,
  output logic            error
);

  state_e          state_q, state_d;
  logic [CRW-1:0]  credit_q, credit_d;
  logic            rd0_q, rd1_q, sel_q;
  logic [CNTW-1:0] cnt0_q, cnt1_q;
  logic            err_q;
  logic            e0, e1, ok, gnt, vc, go;

  assign e0 = !vc0_empty && !(rd0_q && vc0_almost_empty);
  assign e1 = !vc1_empty && !(rd1_q && vc1_almost_empty);
  // a word in flight takes the last free downstream slot
  assign ok = !out_full && (!out_almost_full || !out_wr);

  wrr_pick #(.W0(W0), .W1(W1)) u_pick (
    .state_i  (state_q),
    .credit_i (credit_q),
    .e0_i     (e0),
    .e1_i     (e1),
    .ok_i     (ok),
    .gnt_o    (gnt),
    .vc_o     (vc),
    .state_o  (state_d),
    .credit_o (credit_d)
  );

  assign go     = gnt && !reset;
  assign vc0_rd = go && !vc;
  assign vc1_rd = go && vc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      rd0_q    <= 1'b0;
      rd1_q    <= 1'b0;
      sel_q    <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      rd0_q    <= vc0_rd;
      rd1_q    <= vc1_rd;
      sel_q    <= vc1_rd;
      if (out_wr && !sel_q) cnt0_q <= cnt0_q + 1'b1;
      if (out_wr && sel_q)  cnt1_q <= cnt1_q + 1'b1;
      if ((out_wr && out_full) ||
          (vc0_rd && vc0_empty) ||
          (vc1_rd && vc1_empty) ||
          (vc0_rd && vc1_rd))
        err_q <= 1'b1;
    end
  end

  assign out_wr   = rd0_q || rd1_q;
  assign out_data = !out_wr ? '0 :
                    sel_q   ? vc1_data : vc0_data;
  assign last_vc  = (state_q == SRV1);
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;
  assign error    = err_q;

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Directed bench for vc_wrr_arbiter with a small source FIFO model.
module tb_vc_wrr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vc0_empty, vc1_empty;
  logic        vc0_almost_empty, vc1_almost_empty;
  logic [15:0] vc0_data, vc1_data;
  logic        out_full, out_almost_full;
  logic        vc0_rd, vc1_rd, out_wr, last_vc, error;
  logic [15:0] out_data;
  logic [7:0]  cnt0, cnt1;

  int n_chk = 0;
  int n_err = 0;

  logic       ld, ovr;
  logic [7:0] ld0v, ld1v;
  logic [7:0] m0, m1, p0, p1;

  always #5 clk = ~clk;

  vc_wrr_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .vc0_empty        (vc0_empty),
    .vc1_empty        (vc1_empty),
    .vc0_almost_empty (vc0_almost_empty),
    .vc1_almost_empty (vc1_almost_empty),
    .vc0_data         (vc0_data),
    .vc1_data         (vc1_data),
    .out_full         (out_full),
    .out_almost_full  (out_almost_full),
    .vc0_rd           (vc0_rd),
    .vc1_rd           (vc1_rd),
    .out_wr           (out_wr),
    .out_data         (out_data),
    .last_vc          (last_vc),
    .cnt0             (cnt0),
    .cnt1             (cnt1),
    .error            (error)
  );

  // source FIFO model; ovr pins VC0 flags to "one word, not empty"
  assign vc0_empty        = ovr ? 1'b0 : (m0 == 8'd0);
  assign vc0_almost_empty = ovr ? 1'b1 : (m0 <= 8'd1);
  assign vc1_empty        = (m1 == 8'd0);
  assign vc1_almost_empty = (m1 <= 8'd1);

  always @(posedge clk) begin
    if (ld) begin
      m0 <= ld0v; m1 <= ld1v;
      p0 <= 8'd0; p1 <= 8'd0;
    end else begin
      if (vc0_rd) begin
        m0 <= m0 - 8'd1; p0 <= p0 + 8'd1;
        vc0_data <= 16'hA000 + 16'(p0);
      end
      if (vc1_rd) begin
        m1 <= m1 - 8'd1; p1 <= p1 + 8'd1;
        vc1_data <= 16'hB000 + 16'(p1);
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] a,
                       input logic [7:0] b);
    reset = 1'b1;
    out_full = 1'b0;
    out_almost_full = 1'b0;
    ovr = 1'b0;
    ld0v = a; ld1v = b; ld = 1'b1;
    step();
    ld = 1'b0;
    step();
    reset = 1'b0;
  endtask

  logic       ord [8];
  logic [15:0] dseq [8];
  logic       p2 [8];

  initial begin
    ord  = '{0, 0, 0, 1, 0, 0, 0, 1};
    dseq = '{16'hA000, 16'hA001, 16'hA002, 16'hB000,
             16'hA003, 16'hA004, 16'hA005, 16'hB001};
    p2   = '{1, 1, 1, 0, 1, 0, 0, 0};
    vc0_data = '0; vc1_data = '0;
    reset = 1'b1; ld = 1'b0; ovr = 1'b0;
    ld0v = 8'd8; ld1v = 8'd8;
    out_full = 1'b0; out_almost_full = 1'b0;

    // reset values
    ld = 1'b1;
    step();
    ld = 1'b0;
    @(negedge clk);
    check("rst_rd0", 32'(vc0_rd), 0);
    check("rst_rd1", 32'(vc1_rd), 0);
    check("rst_wr", 32'(out_wr), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_last", 32'(last_vc), 0);
    check("rst_cnt0", 32'(cnt0), 0);
    check("rst_cnt1", 32'(cnt1), 0);
    check("rst_err", 32'(error), 0);

    // weighted order 3:1
    start(8'd8, 8'd8);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      @(negedge clk);
      if (i < 8) begin
        check($sformatf("t1_rd0_%0d", i),
              32'(vc0_rd), 32'(!ord[i]));
        check($sformatf("t1_rd1_%0d", i),
              32'(vc1_rd), 32'(ord[i]));
      end
      check($sformatf("t1_wr_%0d", i),
            32'(out_wr), 32'(i > 0));
      if (i > 0)
        check($sformatf("t1_data_%0d", i),
              32'(out_data), 32'(dseq[i-1]));
    end
    check("t1_cnt0", 32'(cnt0), 6);
    check("t1_cnt1", 32'(cnt1), 1);

    // VC1 only, 4 words, almost_empty gating
    start(8'd0, 8'd4);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      @(negedge clk);
      check($sformatf("t2_rd1_%0d", i),
            32'(vc1_rd), 32'(p2[i]));
      check($sformatf("t2_rd0_%0d", i),
            32'(vc0_rd), 0);
    end
    check("t2_cnt1", 32'(cnt1), 4);
    check("t2_cnt0", 32'(cnt0), 0);
    check("t2_last", 32'(last_vc), 1);

    // downstream back-pressure
    start(8'd8, 8'd8);
    @(negedge clk);
    check("t3_rd_c0", 32'(vc0_rd), 1);
    step();
    out_almost_full = 1'b1;
    @(negedge clk);
    check("t3_afull_wr", 32'(out_wr), 1);
    check("t3_afull_rd", 32'(vc0_rd | vc1_rd), 0);
    step();
    out_full = 1'b1;
    @(negedge clk);
    check("t3_full_rd", 32'(vc0_rd | vc1_rd), 0);
    step();
    out_full = 1'b0;
    out_almost_full = 1'b0;
    @(negedge clk);
    check("t3_resume_rd", 32'(vc0_rd | vc1_rd), 1);
    check("t3_err", 32'(error), 0);

    // single word on VC0
    start(8'd1, 8'd0);
    @(negedge clk);
    check("t4_rd_c0", 32'(vc0_rd), 1);
    step();
    ovr = 1'b1;
    @(negedge clk);
    check("t4_rd_c1", 32'(vc0_rd), 0);
    check("t4_wr_c1", 32'(out_wr), 1);
    check("t4_data", 32'(out_data), 32'h0000A000);
    step();
    ovr = 1'b0;
    @(negedge clk);
    check("t4_rd_c2", 32'(vc0_rd), 0);
    check("t4_wr_c2", 32'(out_wr), 0);
    check("t4_data0", 32'(out_data), 0);
    check("t4_cnt0", 32'(cnt0), 1);

    // reset with a word in flight
    start(8'd8, 8'd8);
    @(negedge clk);
    check("t5_rd_c0", 32'(vc0_rd), 1);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("t5_wr_rst", 32'(out_wr), 0);
    check("t5_cnt0", 32'(cnt0), 0);
    check("t5_rd_rst", 32'(vc0_rd), 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t5_rd_rel", 32'(vc0_rd), 1);
    step();
    @(negedge clk);
    check("t5_wr_rel", 32'(out_wr), 1);
    check("t5_data", 32'(out_data), 32'h0000A001);

    // write into a full downstream FIFO
    start(8'd8, 8'd8);
    @(negedge clk);
    check("t6_rd_c0", 32'(vc0_rd), 1);
    step();
    out_full = 1'b1;
    @(negedge clk);
    check("t6_rd_full", 32'(vc0_rd), 0);
    check("t6_err_pre", 32'(error), 0);
    step();
    out_full = 1'b0;
    @(negedge clk);
    check("t6_err_set", 32'(error), 1);
    step();
    step();
    @(negedge clk);
    check("t6_err_hold", 32'(error), 1);
    reset = 1'b1;
    #1;
    check("t6_err_clr", 32'(error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
